// File: rtl/truth_table_checker.sv
// Exhaustive sweep checker: compares N_CH implementations against channel 0.
// Define TT_CAPTURE_EN to add the tt_map golden minterm capture output.
module truth_table_checker #(
  parameter int N_IN  = 3,
  parameter int N_CH  = 6,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop_on_err,
  input  logic [N_CH-1:0]   res,
  output logic [N_IN-1:0]   vec,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [N_IN-1:0]   fail_vec,
  output logic [N_CH-1:0]   fail_mask
`ifdef TT_CAPTURE_EN
  ,
  output logic [(1<<N_IN)-1:0] tt_map
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_t;

  state_t state, state_nx;

  logic              start_q;
  logic              start_rise;
  logic [N_CH-1:0]   mis;
  logic              any_mis;
  logic              last;
  logic              first;
  logic              finish;
  logic [CNT_W-1:0]  err_nx;

  assign start_rise = start & ~start_q;
  assign mis        = res ^ {N_CH{res[0]}};
  assign any_mis    = |mis;
  assign last       = (vec == '1);
  assign first      = (err_cnt == '0);
  assign finish     = last | (stop_on_err & any_mis);
  assign busy       = (state == SWEEP);
  assign done       = (state == DONE);

  always_comb begin
    err_nx = err_cnt;
    if (state == SWEEP && any_mis && err_cnt != '1)
      err_nx = err_cnt + CNT_W'(1);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start_rise) state_nx = SWEEP;
      SWEEP:   if (finish) state_nx = DONE;
      DONE:    if (start_rise) state_nx = SWEEP;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q   <= 1'b0;
      vec       <= '0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      fail_vec  <= '0;
      fail_mask <= '0;
`ifdef TT_CAPTURE_EN
      tt_map    <= '0;
`endif
    end else begin
      start_q <= start;
      if (state != SWEEP && start_rise) begin
        vec       <= '0;
        pass      <= 1'b0;
        err_cnt   <= '0;
        fail_vec  <= '0;
        fail_mask <= '0;
`ifdef TT_CAPTURE_EN
        tt_map    <= '0;
`endif
      end else if (state == SWEEP) begin
        err_cnt <= err_nx;
        if (any_mis && first) begin
          fail_vec  <= vec;
          fail_mask <= mis;
        end
`ifdef TT_CAPTURE_EN
        tt_map[vec] <= res[0];
`endif
        // results are final on the same edge that leaves the sweep
        if (finish) begin
          vec  <= '0;
          pass <= (err_nx == '0);
        end else begin
          vec <= vec + N_IN'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// Randomized bench for truth_table_checker against a sweep-level reference model.
// A second narrow-counter instance exercises err_cnt saturation.
module tb_truth_table_checker;

  localparam int N_IN  = 3;
  localparam int N_CH  = 6;
  localparam int CNT_W = 8;
  localparam int NV    = 1 << N_IN;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              soe = 1'b0;
  logic [N_CH-1:0]   res;
  logic [N_IN-1:0]   vec;
  logic              busy, done, pass;
  logic [CNT_W-1:0]  err_cnt;
  logic [N_IN-1:0]   fail_vec;
  logic [N_CH-1:0]   fail_mask;
`ifdef TT_CAPTURE_EN
  logic [NV-1:0]     tt_map;
  logic [NV-1:0]     tt_map2;
`endif

  logic              start2 = 1'b0;
  logic [1:0]        res2;
  logic [N_IN-1:0]   vec2;
  logic              busy2, done2, pass2;
  logic [1:0]        err_cnt2;
  logic [N_IN-1:0]   fail_vec2;
  logic [1:0]        fail_mask2;

  logic [NV-1:0]     func;
  logic [N_CH-1:0]   flip [NV];

  int checks = 0;
  int failures = 0;

  int              e_cyc, e_cnt;
  logic [N_IN-1:0] e_fv;
  logic [N_CH-1:0] e_fm;
  logic [NV-1:0]   e_tt;

  always #5 clk = ~clk;

  always_comb res  = {N_CH{func[vec]}} ^ flip[vec];
  always_comb res2 = {~func[vec2], func[vec2]};

  truth_table_checker #(.N_IN(N_IN), .N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop_on_err(soe),
    .res(res), .vec(vec), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_vec(fail_vec), .fail_mask(fail_mask)
`ifdef TT_CAPTURE_EN
    , .tt_map(tt_map)
`endif
  );

  truth_table_checker #(.N_IN(N_IN), .N_CH(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .stop_on_err(1'b0),
    .res(res2), .vec(vec2), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err_cnt2), .fail_vec(fail_vec2), .fail_mask(fail_mask2)
`ifdef TT_CAPTURE_EN
    , .tt_map(tt_map2)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // expected result of one sweep, walked vector by vector
  task automatic model();
    logic [N_CH-1:0] m;
    e_cyc = NV; e_cnt = 0; e_fv = '0; e_fm = '0; e_tt = '0;
    for (int v = 0; v < NV; v++) begin
      m = flip[v] ^ {N_CH{flip[v][0]}};
      e_tt[v] = func[v] ^ flip[v][0];
      if (m != '0) begin
        if (e_cnt == 0) begin
          e_fv = N_IN'(v);
          e_fm = m;
        end
        if (e_cnt < (1 << CNT_W) - 1) e_cnt++;
        if (soe) begin
          e_cyc = v + 1;
          break;
        end
      end
    end
  endtask

  task automatic clear_flips();
    for (int v = 0; v < NV; v++) flip[v] = '0;
  endtask

  task automatic check_result(input string tag);
    chk({tag, ".done"}, done, 1'b1);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".pass"}, pass, e_cnt == 0);
    chk({tag, ".err_cnt"}, err_cnt, e_cnt);
    chk({tag, ".fail_vec"}, fail_vec, e_fv);
    chk({tag, ".fail_mask"}, fail_mask, e_fm);
    chk({tag, ".vec"}, vec, 0);
`ifdef TT_CAPTURE_EN
    chk({tag, ".tt_map"}, tt_map, e_tt);
`endif
  endtask

  task automatic run(input string tag, input bit mid);
    int cyc;
    model();
    @(negedge clk) start = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (busy && cyc < NV + 4) begin
      chk({tag, ".vec_seq"}, vec, cyc);
      start = (mid && cyc == 2);
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, ".cycles"}, cyc, e_cyc);
    check_result(tag);
  endtask

  initial begin
    int cyc;
    func = '0;
    clear_flips();
    repeat (2) @(negedge clk);
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.pass", pass, 1'b0);
    chk("rst.err_cnt", err_cnt, 0);
    chk("rst.vec", vec, 0);
    rst_n = 1'b1;

    func = 8'b1111_0100;
    soe = 1'b0;
    run("t1", 1'b0);
`ifdef TT_CAPTURE_EN
    chk("t1.tt_lit", tt_map, 8'b1111_0100);
`endif

    flip[5] = 6'b010000;
    run("t2", 1'b1);
    chk("t2.mask_lit", fail_mask, 6'b010000);

    clear_flips();
    flip[1] = 6'b100100;
    flip[6] = 6'b100100;
    soe = 1'b1;
    run("t3", 1'b0);

    // reset during the fourth sweep cycle
    soe = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4.pre_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t4.busy", busy, 1'b0);
    chk("t4.err_cnt", err_cnt, 0);
    chk("t4.vec", vec, 0);
    chk("t4.fail_mask", fail_mask, 0);
    chk("t4.fail_vec", fail_vec, 0);
    @(negedge clk) rst_n = 1'b1;
    clear_flips();
    run("t4b", 1'b0);

    // start held high across DONE, then a fresh edge
    flip[2] = 6'b000110;
    run("t5a", 1'b0);
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    chk("t5.restart_busy", busy, 1'b1);
    chk("t5.cleared_cnt", err_cnt, 0);
    chk("t5.cleared_mask", fail_mask, 0);
    cyc = 0;
    while (!done && cyc < 2 * NV) begin
      cyc++;
      @(negedge clk);
    end
    chk("t5.reached_done", done, 1'b1);
    repeat (4) @(negedge clk);
    chk("t5.hold_busy", busy, 1'b0);
    chk("t5.hold_done", done, 1'b1);
    start = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    chk("t5.retrig", busy, 1'b1);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 2 * NV) begin
      cyc++;
      @(negedge clk);
    end
    model();
    check_result("t5b");

    for (int it = 0; it < 20; it++) begin
      func = NV'($urandom);
      for (int v = 0; v < NV; v++)
        flip[v] = ($urandom_range(0, 3) == 0) ? N_CH'($urandom) : '0;
      soe = 1'($urandom_range(0, 1));
      run("rnd", 1'($urandom_range(0, 1)));
    end

    // narrow counter saturates; channel 1 is always inverted
    func = NV'($urandom);
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    cyc = 0;
    while (!done2 && cyc < 2 * NV) begin
      cyc++;
      @(negedge clk);
    end
    chk("t6.done", done2, 1'b1);
    chk("t6.err_cnt", err_cnt2, (NV > 3) ? 3 : NV);
    chk("t6.fail_vec", fail_vec2, 0);
    chk("t6.fail_mask", fail_mask2, 2'b10);
    chk("t6.pass", pass2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
